apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter AW, default 9, meaning the address width; paddr[AW-1] selects the slave.
REQ-002 SHALL have parameter DW, default 8, meaning the data width.
REQ-003 SHALL have port pclk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port presetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port transfer  input  1  request to start an APB transfer.
REQ-006 SHALL have port read_write  input  1  transfer direction: 1 = read, 0 = write.
REQ-007 SHALL have port apb_write_paddr  input  AW  write address.
REQ-008 SHALL have port apb_read_paddr  input  AW  read address.
REQ-009 SHALL have port apb_write_data  input  DW  write data.
REQ-010 SHALL have port apb_read_data_out  output  DW  last completed read data.
REQ-011 SHALL have ports paddr (output, AW), pwdata (output, DW), pwrite (output, 1), penable (output, 1), psel1 (output, 1) and psel2 (output, 1): the APB master bus.
REQ-012 SHALL have ports prdata1 and prdata2 (input, DW), pready1 and pready2 (input, 1), and pslverr1 and pslverr2 (input, 1): the slave responses.
REQ-013 SHALL have ports done (output, 1), a one-cycle completion pulse, and err (output, 1), an error flag that is valid while done is high.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-015 In IDLE, on transfer=1, SHALL capture read_write, the address (apb_read_paddr if read, else apb_write_paddr) and apb_write_data into registers, then go to SETUP.
REQ-016 SETUP SHALL assert the selected psel (psel1 if paddr[AW-1]=0, else psel2) with penable=0 and go to ACCESS unconditionally after one cycle.
REQ-017 ACCESS SHALL hold psel=1 and penable=1, and paddr, pwdata and pwrite stable, until the selected pready is 1.
REQ-018 Only the selected slave's pready, prdata and pslverr SHALL be considered; the unselected slave's signals SHALL be ignored.
REQ-019 On completion of a read, SHALL load apb_read_data_out from the selected prdata at the same edge.
REQ-020 On completion, SHALL pulse done for one cycle and set err equal to the selected pslverr.
REQ-021 On a write, apb_read_data_out SHALL be unchanged.
REQ-022 On completion with transfer=1, SHALL capture a new request and go to SETUP (back-to-back transfer); otherwise SHALL go to IDLE.
REQ-023 Minimum latency: transfer sampled at edge N gives SETUP in N..N+1 and ACCESS in N+1..N+2; done is high in the cycle after the completing edge; 3 cycles per transfer with zero wait states.
REQ-024 transfer SHALL be ignored in SETUP and in ACCESS while waiting.
REQ-025 psel1 and psel2 SHALL never both be 1.

Reset
REQ-026 When presetn=0, SHALL immediately force IDLE, with psel1, psel2, penable, pwrite, done and err at 0, and paddr, pwdata and apb_read_data_out at 0.
REQ-027 Reset mid-transfer SHALL abort without producing done, and the first request after release SHALL start from IDLE.

Configuration
REQ-028 With APB_TIMEOUT_EN defined, a 4-bit wait counter SHALL clear on entry to ACCESS and increment for each ACCESS cycle with pready=0.
REQ-029 With APB_TIMEOUT_EN defined, on the 16th consecutive wait cycle SHALL abort to IDLE, pulse done with err=1 and leave apb_read_data_out unchanged.
REQ-030 Without APB_TIMEOUT_EN, SHALL wait in ACCESS indefinitely, with no counter logic present.

Verification
REQ-031 Write of 0xA5 to address 0x005 with pready1=1 -> psel1=1 in SETUP, penable=1 in ACCESS, pwdata=0xA5, done after 3 cycles, err=0, psel2 never 1.
REQ-032 Read of address 0x105 with prdata2=0x3C, pready2 low for 2 cycles -> ACCESS lasts 3 cycles, apb_read_data_out=0x3C, done=1 once.
REQ-033 transfer held high across two reads (0x010, then 0x110) -> second SETUP immediately after the first ACCESS, with no IDLE cycle between transfers.
REQ-034 pslverr1=1 at completion of a write -> done=1 with err=1.
REQ-035 presetn pulsed low during ACCESS -> all outputs 0 asynchronously and no done.
REQ-036 With APB_TIMEOUT_EN defined, pready1 held at 0 -> abort after 16 wait cycles with done=1 and err=1; without the macro, the controller stays in ACCESS.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB master controller with two slaves (optional wait timeout: APB_TIMEOUT_EN)
module apb_master_ctrl #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_write_data,
  output logic [DW-1:0] apb_read_data_out,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          pwrite,
  output logic          penable,
  output logic          psel1,
  output logic          psel2,
  input  logic [DW-1:0] prdata1,
  input  logic [DW-1:0] prdata2,
  input  logic          pready1,
  input  logic          pready2,
  input  logic          pslverr1,
  input  logic          pslverr2,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          pwrite_q;
  logic [DW-1:0] rdata_q;
  logic          done_q;
  logic          err_q;

  logic          capture;
  logic          complete;
  logic          abort;

  // Only the slave addressed by the captured request is listened to
  logic          slave2;
  logic          sel_ready;
  logic          sel_err;
  logic [DW-1:0] sel_rdata;

  assign slave2    = paddr_q[AW-1];
  assign sel_ready = slave2 ? pready2  : pready1;
  assign sel_err   = slave2 ? pslverr2 : pslverr1;
  assign sel_rdata = slave2 ? prdata2  : prdata1;

`ifdef APB_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Count consecutive wait cycles in ACCESS; cleared while in SETUP so each ACCESS starts at zero
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= 4'd0;
    end else if (state_q == SETUP) begin
      wait_cnt <= 4'd0;
    end else if (state_q == ACCESS && !sel_ready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // The 16th wait cycle is the one seen while the counter already holds 15
  assign abort = (state_q == ACCESS) && !sel_ready && (wait_cnt == 4'd15);
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completing ACCESS may chain straight into the next SETUP
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          complete = 1'b1;
          if (transfer) begin
            capture = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture, read-data load and completion status
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (capture) begin
        paddr_q  <= read_write ? apb_read_paddr : apb_write_paddr;
        pwdata_q <= apb_write_data;
        pwrite_q <= ~read_write;
      end
      if (complete && !pwrite_q) begin
        rdata_q <= sel_rdata;
      end
      done_q <= complete | abort;
      err_q  <= complete ? sel_err : abort;
    end
  end

  assign paddr             = paddr_q;
  assign pwdata            = pwdata_q;
  assign pwrite            = pwrite_q;
  assign penable           = (state_q == ACCESS);
  assign psel1             = (state_q != IDLE) && !slave2;
  assign psel2             = (state_q != IDLE) && slave2;
  assign apb_read_data_out = rdata_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed bench for apb_master_ctrl
module tb_apb_master_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          pclk;
  logic          presetn;
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          penable;
  logic          psel1;
  logic          psel2;
  logic [DW-1:0] prdata1;
  logic [DW-1:0] prdata2;
  logic          pready1;
  logic          pready2;
  logic          pslverr1;
  logic          pslverr2;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_ctrl #(.AW(AW), .DW(DW)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .pwrite            (pwrite),
    .penable           (penable),
    .psel1             (psel1),
    .psel2             (psel2),
    .prdata1           (prdata1),
    .prdata2           (prdata2),
    .pready1           (pready1),
    .pready2           (pready2),
    .pslverr1          (pslverr1),
    .pslverr2          (pslverr2),
    .done              (done),
    .err               (err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel1"},   psel1, 0);
    check({tag, "_psel2"},   psel2, 0);
    check({tag, "_penable"}, penable, 0);
    check({tag, "_pwrite"},  pwrite, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_err"},     err, 0);
    check({tag, "_paddr"},   paddr, 0);
    check({tag, "_pwdata"},  pwdata, 0);
    check({tag, "_rdata"},   apb_read_data_out, 0);
  endtask

  // Both selects must never be high together
  always @(negedge pclk) begin
    if (presetn) check("psel_exclusive", psel1 & psel2, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cycles;
    int done_seen;
    int err_seen;

    presetn = 1'b0; transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
    prdata1 = '0; prdata2 = '0; pready1 = 1'b1; pready2 = 1'b1;
    pslverr1 = 1'b0; pslverr2 = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    presetn = 1'b1;
    tick();

    // Write 0xA5 to 0x005, slave 1, zero wait states
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h005; apb_write_data = 8'hA5;
    tick();
    transfer = 1'b0;
    check("wr_setup_psel1", psel1, 1);
    check("wr_setup_psel2", psel2, 0);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_paddr", paddr, 9'h005);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_pwdata", pwdata, 8'hA5);
    tick();
    check("wr_access_psel1", psel1, 1);
    check("wr_access_psel2", psel2, 0);
    check("wr_access_penable", penable, 1);
    check("wr_access_done", done, 0);
    tick();
    check("wr_done", done, 1);
    check("wr_err", err, 0);
    check("wr_idle_psel1", psel1, 0);
    check("wr_rdata_unchanged", apb_read_data_out, 0);
    tick();
    check("wr_done_pulse", done, 0);

    // Read 0x105 from slave 2 with two wait cycles; slave 1 noise must be ignored
    prdata1 = 8'hFF; pslverr1 = 1'b1; pready1 = 1'b1;
    prdata2 = 8'h3C; pready2 = 1'b0; pslverr2 = 1'b0;
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h105; apb_write_paddr = 9'h0AA;
    tick();
    transfer = 1'b0;
    check("rd_setup_psel2", psel2, 1);
    check("rd_setup_psel1", psel1, 0);
    check("rd_setup_paddr", paddr, 9'h105);
    check("rd_setup_pwrite", pwrite, 0);
    acc_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (penable === 1'b1 && psel2 === 1'b1) acc_cycles++;
      check("rd_wait_done", done, 0);
      if (i == 2) pready2 = 1'b1;
    end
    check("rd_access_cycles", acc_cycles, 3);
    tick();
    check("rd_done", done, 1);
    check("rd_err_slave2_only", err, 0);
    check("rd_data", apb_read_data_out, 8'h3C);
    tick();
    check("rd_done_once", done, 0);
    check("rd_data_hold", apb_read_data_out, 8'h3C);

    // Back-to-back reads 0x010 then 0x110
    pslverr1 = 1'b0; prdata1 = 8'h11; prdata2 = 8'h22;
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h010;
    tick();
    check("b2b_setup1_psel1", psel1, 1);
    check("b2b_setup1_paddr", paddr, 9'h010);
    apb_read_paddr = 9'h110;
    tick();
    check("b2b_access1_penable", penable, 1);
    check("b2b_access1_paddr_stable", paddr, 9'h010);
    tick();
    transfer = 1'b0;
    check("b2b_setup2_psel2", psel2, 1);
    check("b2b_setup2_penable", penable, 0);
    check("b2b_setup2_paddr", paddr, 9'h110);
    check("b2b_done1", done, 1);
    check("b2b_data1", apb_read_data_out, 8'h11);
    tick();
    check("b2b_access2_penable", penable, 1);
    check("b2b_access2_done", done, 0);
    tick();
    check("b2b_done2", done, 1);
    check("b2b_data2", apb_read_data_out, 8'h22);
    check("b2b_idle_psel2", psel2, 0);

    // Write with slave error
    pslverr1 = 1'b1;
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h020; apb_write_data = 8'h5A;
    tick();
    transfer = 1'b0;
    tick();
    tick();
    check("slverr_done", done, 1);
    check("slverr_err", err, 1);
    check("slverr_rdata_unchanged", apb_read_data_out, 8'h22);
    pslverr1 = 1'b0;
    tick();
    check("slverr_done_clear", done, 0);
    check("slverr_err_clear", err, 0);

    // Reset asserted mid-ACCESS
    pready1 = 1'b0;
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h0F0; apb_write_data = 8'h77;
    tick();
    transfer = 1'b0;
    tick();
    check("rst_pre_penable", penable, 1);
    #2;
    presetn = 1'b0;
    #1;
    check_all_zero("rst_async");
    pready1 = 1'b1;
    tick();
    presetn = 1'b1;
    tick();
    check("rst_no_done", done, 0);
    check("rst_idle_psel1", psel1, 0);
    transfer = 1'b1; read_write = 1'b0; apb_write_paddr = 9'h003; apb_write_data = 8'h33;
    tick();
    transfer = 1'b0;
    check("rst_after_setup_psel1", psel1, 1);
    check("rst_after_setup_penable", penable, 0);
    check("rst_after_setup_paddr", paddr, 9'h003);
    tick();
    check("rst_after_access_penable", penable, 1);
    tick();
    check("rst_after_done", done, 1);

    // Slave 1 never ready: timeout abort or indefinite wait
    prdata1 = 8'h99; pready1 = 1'b0;
    transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h004;
    tick();
    transfer = 1'b0;
    acc_cycles = 0; done_seen = 0; err_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) begin
        done_seen = 1;
        err_seen = err;
        break;
      end
      if (penable === 1'b1) acc_cycles++;
    end
`ifdef APB_TIMEOUT_EN
    check("to_access_cycles", acc_cycles, 16);
    check("to_done", done_seen, 1);
    check("to_err", err_seen, 1);
    check("to_idle_penable", penable, 0);
    check("to_rdata_unchanged", apb_read_data_out, 0);
`else
    check("nto_access_cycles", acc_cycles, 30);
    check("nto_no_done", done_seen, 0);
    check("nto_still_access", penable, 1);
`endif
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    pready1 = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
